// File: rtl/grid_io_bank_cfg_pkg.sv
// Shared constants and FSM state type for the I/O bank configuration tile.
package grid_io_bank_cfg_pkg;

    localparam int unsigned CFG_BITS_PER_IO = 3;
    localparam int unsigned CFG_EN          = 0;
    localparam int unsigned CFG_DIR         = 1;
    localparam int unsigned CFG_INV         = 2;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/grid_io_bank_cell.sv
// Combinational pad cell: routes fabric/pad data according to its active config bits.
module grid_io_bank_cell
    import grid_io_bank_cfg_pkg::*;
#(
    parameter logic DIR_OUTPUT_LEVEL = 1'b0
) (
    input  logic                       isol_n,
    input  logic                       cfg_valid,
    input  logic [CFG_BITS_PER_IO-1:0] cfg,
    input  logic                       soc_in,
    input  logic                       fabric_out,
    output logic                       soc_out_c,
    output logic                       soc_dir_c,
    output logic                       io_inpad_c
);

    // Safe state unless isolation is released, config is valid and the cell is enabled.
    always_comb begin
        soc_dir_c  = ~DIR_OUTPUT_LEVEL;
        soc_out_c  = 1'b0;
        io_inpad_c = 1'b0;
        if (isol_n && cfg_valid && cfg[CFG_EN]) begin
            if (cfg[CFG_DIR]) begin
                soc_dir_c = DIR_OUTPUT_LEVEL;
                soc_out_c = fabric_out ^ cfg[CFG_INV];
            end else begin
                io_inpad_c = soc_in ^ cfg[CFG_INV];
            end
        end
    end

endmodule

// File: rtl/grid_io_bank_cfg.sv
// I/O bank tile: serial shadow config chain, checked atomic commit into active config, NUM_IO pad cells.
module grid_io_bank_cfg
    import grid_io_bank_cfg_pkg::*;
#(
    parameter int unsigned NUM_IO           = 4,
    parameter logic        DIR_OUTPUT_LEVEL = 1'b0
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              isol_n,
    input  logic              ccff_head,
    input  logic              ccff_shift,
    input  logic              ccff_commit,
    output logic              ccff_tail,
    output logic              cfg_valid,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic [NUM_IO-1:0] gfpga_pad_io_soc_in,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_out,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir,
    input  logic [NUM_IO-1:0] io_outpad,
    output logic [NUM_IO-1:0] io_inpad
);

    localparam int unsigned TOTAL = CFG_BITS_PER_IO * NUM_IO;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);

    logic [TOTAL-1:0] shadow_q, shadow_d;
    logic [TOTAL-1:0] active_q, active_d;
    logic [CNT_W-1:0] count_q, count_d;
    cfg_state_e       state_q, state_d;
    logic             valid_d, done_d, err_d;
    logic             commit_ok;

    // A commit is only accepted on a fully loaded chain with no shift in the same cycle.
    assign commit_ok = ccff_commit && !ccff_shift && (state_q == FULL);

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        count_d  = count_q;
        state_d  = state_q;
        valid_d  = cfg_valid;
        done_d   = 1'b0;
        err_d    = cfg_err;

        if (ccff_shift) begin
            shadow_d = {shadow_q[TOTAL-2:0], ccff_head};
            if (count_q != CNT_W'(TOTAL)) begin
                count_d = count_q + CNT_W'(1);
            end
        end

        if (ccff_commit) begin
            count_d = '0;
            if (commit_ok) begin
                active_d = shadow_q;
                valid_d  = 1'b1;
                done_d   = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // State mirrors the saturating shift count.
        if (count_d == '0) begin
            state_d = EMPTY;
        end else if (count_d == CNT_W'(TOTAL)) begin
            state_d = FULL;
        end else begin
            state_d = PARTIAL;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            shadow_q  <= '0;
            active_q  <= '0;
            count_q   <= '0;
            state_q   <= EMPTY;
            cfg_valid <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            count_q   <= count_d;
            state_q   <= state_d;
            cfg_valid <= valid_d;
            cfg_done  <= done_d;
            cfg_err   <= err_d;
        end
    end

    assign ccff_tail = shadow_q[TOTAL-1];

    for (genvar k = 0; k < NUM_IO; k++) begin : g_cell
        grid_io_bank_cell #(
            .DIR_OUTPUT_LEVEL(DIR_OUTPUT_LEVEL)
        ) u_cell (
            .isol_n     (isol_n),
            .cfg_valid  (cfg_valid),
            .cfg        (active_q[k*CFG_BITS_PER_IO +: CFG_BITS_PER_IO]),
            .soc_in     (gfpga_pad_io_soc_in[k]),
            .fabric_out (io_outpad[k]),
            .soc_out_c  (gfpga_pad_io_soc_out[k]),
            .soc_dir_c  (gfpga_pad_io_soc_dir[k]),
            .io_inpad_c (io_inpad[k])
        );
    end

endmodule

// File: doc/grid_io_bank_cfg.md
# grid_io_bank_cfg

Parametrised I/O bank tile: NUM_IO pad cells with a shadow configuration chain that is shifted serially and committed atomically into active configuration registers. It sits in the configuration daisy chain between neighbouring tiles (ccff_head in, ccff_tail out) and connects fabric pins to SoC pad signals. The chain counts shifts so that commits are safe, and commits are checked. Each cell supports enable, direction and polarity-inversion modes.

## Interface
Parameters:
- NUM_IO, 4: number of pad cells (1..64).
- DIR_OUTPUT_LEVEL, 1'b0: value driven on gfpga_pad_io_soc_dir when a cell drives the pad. The inverse of this value means input.

Ports:
- prog_clk  in  1  sole clock; all state updates on rising edge.
- prog_reset  in  1  asynchronous, active-low reset.
- isol_n  in  1  active-low isolation; 0 forces all cells to safe state.
- ccff_head  in  1  serial configuration input.
- ccff_shift  in  1  shift enable for the chain.
- ccff_commit  in  1  single-cycle request to load shadow into active.
- ccff_tail  out  1  serial configuration output, equal to shadow MSB.
- cfg_valid  out  1  set after the first successful commit.
- cfg_done  out  1  one-cycle pulse on a successful commit.
- cfg_err  out  1  sticky flag for a rejected commit.
- gfpga_pad_io_soc_in  in  NUM_IO  pad-to-core data.
- gfpga_pad_io_soc_out  out  NUM_IO  core-to-pad data.
- gfpga_pad_io_soc_dir  out  NUM_IO  pad direction.
- io_outpad  in  NUM_IO  fabric data to pads.
- io_inpad  out  NUM_IO  pad data to fabric.

## Operation
- TOTAL = 3*NUM_IO. The shadow register is TOTAL bits wide and the active register is TOTAL bits wide.
- Cell k uses these shadow/active bits:
  - [3k] en
  - [3k+1] dir_out
  - [3k+2] inv
- Shift operation, when ccff_shift=1: shadow <= {shadow[TOTAL-2:0], ccff_head}.
  - ccff_tail = shadow[TOTAL-1], taken directly from the register.
  - The first bit shifted in lands in the IO(NUM_IO-1) inv position.
- The shift counter is clog2(TOTAL+1) bits wide and saturates at TOTAL. Bits passing through for downstream tiles are therefore legal.
- The FSM reflects the counter:
  - EMPTY: count=0.
  - PARTIAL: 0 < count < TOTAL.
  - FULL: count=TOTAL.
- ccff_commit in FULL with ccff_shift=0:
  - active <= shadow
  - count <= 0, state goes to EMPTY
  - cfg_valid <= 1
  - cfg_done pulses
  - shadow is unchanged.
- ccff_commit in EMPTY or PARTIAL: no load, cfg_err <= 1, count <= 0.
- ccff_commit together with ccff_shift: the shift is performed, the commit is rejected (cfg_err <= 1, no load) and count is reset to 0.
- cfg_err stays set until reset.
- Cell datapath is combinational from the active register:
  - Safe state applies if isol_n=0, cfg_valid=0 or en=0. Safe state is: soc_dir = ~DIR_OUTPUT_LEVEL, soc_out = 0, io_inpad = 0.
  - Otherwise, if dir_out=1: soc_dir = DIR_OUTPUT_LEVEL, soc_out = io_outpad ^ inv, io_inpad = 0.
  - Otherwise (input mode): soc_dir = ~DIR_OUTPUT_LEVEL, soc_out = 0, io_inpad = soc_in ^ inv.

## Timing
- Reset values: shadow=0, active=0, count=0, state EMPTY, cfg_valid=0, cfg_done=0, cfg_err=0. Resulting outputs:
  - ccff_tail=0
  - soc_out=0
  - soc_dir = ~DIR_OUTPUT_LEVEL
  - io_inpad=0.
- Reset asserted mid-shift or mid-commit clears everything immediately, independent of the clock. No partial load survives.
- Shift latency: ccff_tail reflects the new shadow MSB right after the shifting edge. Shadow is a pure TOTAL-cycle delay line.
- Commit latency: the active register, cfg_valid and cfg_done update at the commit edge. Pad outputs change in the same cycle, after the edge.
- cfg_done is high for exactly one cycle.
- A back-to-back commit in the next cycle sees count=0 and is rejected.
- isol_n takes effect combinationally with zero-cycle latency. It does not alter any register.

## Structure
- Package grid_io_bank_cfg_pkg holds:
  - CFG_BITS_PER_IO=3
  - bit offsets CFG_EN=0, CFG_DIR=1, CFG_INV=2
  - the state enum {EMPTY, PARTIAL, FULL}.
- Sub-module grid_io_bank_cell: a combinational per-cell datapath with inputs isol_n, cfg_valid, 3 config bits and pad/fabric bits. It is instantiated NUM_IO times in a generate loop.
- The top level holds the shadow register, active register, counter/FSM and flags.

## Test plan
All scenarios use NUM_IO=4, TOTAL=12, DIR_OUTPUT_LEVEL=0.
- Reset check: release reset → all soc_dir=4'b1111, soc_out=0, io_inpad=0, ccff_tail=0, all flags 0.
- Program and commit: shift in 12 bits, first to last 0,0,1, 0,0,0, 1,0,1, 0,1,1, then commit. Expected:
  - cfg_done pulses once, cfg_valid=1.
  - IO0 is output: soc_dir[0]=0, soc_out[0] follows io_outpad[0].
  - IO1 is inverted input: io_inpad[1] = ~soc_in[1].
  - IO2 is disabled and in safe state.
  - IO3 is input: io_inpad[3] = soc_in[3].
- Short shift: commit after 7 shifts → cfg_err=1, active register unchanged, outputs unchanged.
- Pass-through: shift 20 bits → ccff_tail at shift n+12 equals the bit driven at shift n; commit succeeds.
- Simultaneous shift and commit in FULL → shift occurs, cfg_err=1, no load, count=0.
- Isolation and reset: isol_n=0 after programming → all cells safe. Assert prog_reset mid-shift → all values return to reset immediately.
